mux_arb_reg: RTL
================

MUX_ARB_REG -- requirements
Module: mux_arb_reg

Interface
REQ-001 Parameter W, default 8: data width per channel, W >= 1.
REQ-002 Parameter N, default 4: channel count, N >= 2.
REQ-003 Parameter SW, default $clog2(N): select/channel-index width.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1: reset, asynchronous, active-high.
REQ-006 Port in_data  input  N*W: channel i occupies bits [i*W +: W].
REQ-007 Port in_valid  input  N: channel i offers a word.
REQ-008 Port in_ready  output  N: channel i word accepted this cycle.
REQ-009 Port mode  input  1: 0 = fixed select, 1 = round-robin.
REQ-010 Port sel  input  SW: channel index used when mode = 0.
REQ-011 Port out_data  output  W: registered selected word.
REQ-012 Port out_valid  output  1: out_data holds a word.
REQ-013 Port out_ready  input  1: downstream accepts the word.
REQ-014 Port out_ch  output  SW: source channel of out_data.

Function
REQ-015 Transfer in: in_valid[i] & in_ready[i] on a clock edge; transfer out: out_valid & out_ready on a clock edge.
REQ-016 Output stage is one register; load_en = ~out_valid | out_ready.
REQ-017 At most one in_ready bit is high per cycle; in_ready[i] = grant[i] & load_en.
REQ-018 in_ready is combinational from in_valid, mode, sel, out_valid, out_ready, and the pointer; it does not depend on in_data.
REQ-019 Mode 0: grant[sel] = in_valid[sel]; all other grants are 0.
REQ-020 Mode 0 with sel >= N: no grant.
REQ-021 Mode 1: grant goes to the first valid channel searching ptr+1, ptr+2, ... with modulo-N wrap.
REQ-022 Mode 1 with no in_valid set: no grant.
REQ-023 On transfer in: out_data <= granted word, out_ch <= granted index, out_valid <= 1.
REQ-024 On transfer in with mode = 1: ptr <= granted index.
REQ-025 The pointer holds in mode 0 and on cycles without a transfer in.
REQ-026 Transfer out without transfer in: out_valid <= 0; out_data and out_ch hold.
REQ-027 Simultaneous transfer out and transfer in: new word loads in the same cycle (full throughput, one word per cycle).
REQ-028 out_valid = 1 and out_ready = 0: out_data, out_ch, and out_valid hold stable; all in_ready = 0.
REQ-029 Latency: in-transfer at edge k makes the word visible at out_data after edge k.
REQ-030 mode or sel changes apply from the cycle they change; no word is lost or duplicated.
REQ-031 Wrap-around: ptr = N-1 searches 0 first; ptr = last valid channel with only that channel valid re-grants it.

Reset
REQ-032 rst high asynchronously forces out_valid = 0, out_data = 0, out_ch = 0, ptr = N-1, all in_ready = 0.
REQ-033 The first round-robin grant after reset favours channel 0.
REQ-034 Reset mid-transfer discards the held output word; no partial state survives.
REQ-035 Release is synchronous to clk; the first transfer is possible on the first edge with rst low.

Structure
REQ-036 Shared package mux_pkg holds MODE_FIXED = 0 and MODE_RR = 1 constants and the clog2 helper; there are no typedefs beyond these.
REQ-037 Sub-module rr_arbiter (parameter N; inputs req[N], ptr[SW]; outputs grant[N], idx[SW], any) is purely combinational and rotate-priority.
REQ-038 The top level holds the output register, pointer register, mode mux, and the data mux indexed by the grant index.
REQ-039 Target size is 120-400 RTL lines total.

Verification (N=4, W=8)
REQ-040 Reset sequence:
- Stimulus: rst pulse mid-cycle while out_valid = 1.
- Response: outputs zero immediately; ptr = 3.
- Response: next RR grant goes to ch0 with in_valid = 4'b1111.
REQ-041 Round-robin rotation:
- Stimulus: mode = 1, in_valid = 4'b1111, out_ready = 1, data 8'hA0..A3.
- Response: out_ch sequence 0,1,2,3,0; out_data A0,A1,A2,A3,A0; one word per cycle.
REQ-042 Round-robin skip:
- Stimulus: mode = 1, in_valid = 4'b1010.
- Response: grants 1,3,1,3; channels 0 and 2 never ready.
REQ-043 Backpressure:
- Stimulus: out_valid = 1 with out_ready = 0 for 5 cycles.
- Response: out_data stable; in_ready = 0.
- Stimulus: then out_ready = 1.
- Response: next word loads the same cycle.
REQ-044 Fixed mode:
- Stimulus: mode = 0, sel = 2, in_valid = 4'b0100, data 8'h5C.
- Response: out_data = 5C, out_ch = 2; ptr unchanged.
- Stimulus: sel = 2, in_valid = 4'b1011.
- Response: no transfer.
REQ-045 Mode switch:
- Stimulus: mode 1 -> 0 -> 1 mid-stream.
- Response: no dropped or duplicated word (scoreboard count matches).
- Response: RR resumes from the last RR-granted channel + 1.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and the width helper for the registered channel multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_reg_if.sv
// Channel-side and downstream-side handshake bundle of mux_arb_reg.
interface mux_arb_reg_if #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = mux_pkg::clog2(N)
) ();

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_ch;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: the first requester after ptr wins.
module rr_arbiter import mux_pkg::*; #(
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx,
  output logic          any
);

  // Search ptr+1, ptr+2, ... wrapping modulo N; ptr itself is searched last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                           = 1'b1;
        idx                           = SW'((int'(ptr) + k) % N);
        grant[(int'(ptr) + k) % N]    = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel mux with fixed or round-robin selection into a single output register.
module mux_arb_reg import mux_pkg::*; #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input logic          clk,
  input logic          rst,
  mux_arb_reg_if.slave bus
);

  logic [N-1:0]  fix_grant_s;
  logic [N-1:0]  rr_grant_s;
  logic [N-1:0]  grant_s;
  logic [SW-1:0] rr_idx_s;
  logic [SW-1:0] idx_s;
  logic          rr_any_s;
  logic          any_s;
  logic          load_en_s;
  logic          xfer_in_s;
  logic [W-1:0]  word_s;

  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req   (bus.in_valid),
    .ptr   (ptr_q),
    .grant (rr_grant_s),
    .idx   (rr_idx_s),
    .any   (rr_any_s)
  );

  // Grant selection, data mux and handshake; an out-of-range sel matches no channel.
  always_comb begin
    fix_grant_s = '0;
    for (int i = 0; i < N; i++) begin
      fix_grant_s[i] = bus.in_valid[i] & (bus.sel == SW'(i));
    end
    if (bus.mode == MODE_RR) begin
      grant_s = rr_grant_s;
      idx_s   = rr_idx_s;
      any_s   = rr_any_s;
    end else begin
      grant_s = fix_grant_s;
      idx_s   = bus.sel;
      any_s   = |fix_grant_s;
    end
    load_en_s = ~out_valid_q | bus.out_ready;
    xfer_in_s = any_s & load_en_s & ~rst;
    word_s    = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_s == SW'(i)) begin
        word_s = bus.in_data[i*W +: W];
      end else begin
        word_s = word_s;
      end
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_in_s) begin
      out_data_d  = word_s;
      out_ch_d    = idx_s;
      out_valid_d = 1'b1;
      if (bus.mode == MODE_RR) begin
        ptr_d = idx_s;
      end else begin
        ptr_d = ptr_q;
      end
    end else if (out_valid_q & bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset leaves ptr at N-1 so channel 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  // Drive the bundle outputs.
  always_comb begin
    bus.in_ready  = grant_s & {N{xfer_in_s}};
    bus.out_data  = out_data_q;
    bus.out_valid = out_valid_q;
    bus.out_ch    = out_ch_q;
  end

endmodule
